regfile_wb_dual: RTL and testbench

- Parametrised, clocked register file with integrated write-back stage for the Y86-64 core.
- Two write ports:
  - E port: ALU result, used by cmovXX, irmovq, OPq, rsp updates.
  - M port: memory result, used by mrmovq and popq.
- Two combinational read ports with optional same-cycle write-to-read bypass.
- Full-file dump output for the bench.
- Serves both the sequential and pipelined cores; the pipeline drives it from the W stage.

---
 rtl/regfile_wb_dual.sv | 110 +++++++++++
 tb/tb_regfile_wb_dual.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_dual.sv
// Y86-64 register file with an integrated write-back stage: E and M write ports, two
// combinational read ports with optional same-cycle forwarding, and a full-file dump.
module regfile_wb_dual #(
  parameter int                DATA_W   = 64,
  parameter int                NUM_REGS = 15,
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RNONE    = 4'hF,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          dstE,
  input  logic [DATA_W-1:0]          valE,
  input  logic [ADDR_W-1:0]          dstM,
  input  logic [DATA_W-1:0]          valM,
  input  logic [ADDR_W-1:0]          srcA,
  input  logic [ADDR_W-1:0]          srcB,
  output logic [DATA_W-1:0]          rvalA,
  output logic [DATA_W-1:0]          rvalB,
  output logic [NUM_REGS*DATA_W-1:0] reg_dump,
  output logic [31:0]                wb_count
);

  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [31:0]       r_wb_count;
  logic              r_armed;

  logic              w_we_e;
  logic              w_we_m;
  logic              w_any_wr;
  logic [DATA_W-1:0] w_rval_a;
  logic [DATA_W-1:0] w_rval_b;

  function automatic logic spec_valid(input logic [ADDR_W-1:0] spec);
    if (spec == RNONE) begin
      return 1'b0;
    end else begin
      return ({1'b0, spec} < LP_NUM_REGS);
    end
  endfunction

  // r_armed is low on the first edge after reset release, so a write launched
  // against that edge is dropped no matter how release and clock are ordered.
  assign w_we_e   = r_armed & wb_en & spec_valid(dstE);
  assign w_we_m   = r_armed & wb_en & spec_valid(dstM);
  assign w_any_wr = w_we_e | w_we_m;

  // Register array, write-back counter and post-reset arming flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
      r_wb_count <= 32'd0;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_we_e) begin
        r_regs[dstE] <= valE;
      end
      // M is assigned last so it wins a same-register collision (popq %rsp).
      if (w_we_m) begin
        r_regs[dstM] <= valM;
      end
      if (w_any_wr) begin
        r_wb_count <= r_wb_count + 32'd1;
      end
    end
  end

  // Read port A: forwarding mirrors write priority, M ahead of E.
  always_comb begin
    w_rval_a = {DATA_W{1'b0}};
    if (!spec_valid(srcA)) begin
      w_rval_a = {DATA_W{1'b0}};
    end else if (BYPASS && w_we_m && (srcA == dstM)) begin
      w_rval_a = valM;
    end else if (BYPASS && w_we_e && (srcA == dstE)) begin
      w_rval_a = valE;
    end else begin
      w_rval_a = r_regs[srcA];
    end
  end

  // Read port B: identical to port A.
  always_comb begin
    w_rval_b = {DATA_W{1'b0}};
    if (!spec_valid(srcB)) begin
      w_rval_b = {DATA_W{1'b0}};
    end else if (BYPASS && w_we_m && (srcB == dstM)) begin
      w_rval_b = valM;
    end else if (BYPASS && w_we_e && (srcB == dstE)) begin
      w_rval_b = valE;
    end else begin
      w_rval_b = r_regs[srcB];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
    assign reg_dump[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign rvalA    = w_rval_a;
  assign rvalB    = w_rval_b;
  assign wb_count = r_wb_count;

endmodule

// File: tb/tb_regfile_wb_dual.sv
// Bench for regfile_wb_dual: a forwarding and a non-forwarding instance share stimulus and
// are checked every cycle against a spec-level model, plus hand-computed literal checks.
module tb_regfile_wb_dual;

  logic          clk;
  logic          reset_n;
  logic          wb_en;
  logic [3:0]    dstE, dstM, srcA, srcB;
  logic [63:0]   valE, valM;
  logic [63:0]   rvalA_b, rvalB_b, rvalA_n, rvalB_n;
  logic [959:0]  dump_b, dump_n;
  logic [31:0]   cnt_b, cnt_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_regs [15];
  logic [31:0] m_count;
  bit          m_armed;

  regfile_wb_dual #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .wb_en(wb_en),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA_b), .rvalB(rvalB_b),
    .reg_dump(dump_b), .wb_count(cnt_b)
  );

  regfile_wb_dual #(.BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .wb_en(wb_en),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA_n), .rvalB(rvalB_n),
    .reg_dump(dump_n), .wb_count(cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] slot(input logic [959:0] d, input int i);
    return d[i*64 +: 64];
  endfunction

  function automatic bit m_valid(input logic [3:0] s);
    return (s != 4'hF) && (s < 4'd15);
  endfunction

  // Spec-level read: invalid -> 0, forward M then E while writing, else stored value.
  function automatic logic [63:0] m_read(input logic [3:0] s, input bit byp);
    if (!m_valid(s)) return 64'd0;
    if (byp && m_armed && wb_en && dstM == s) return valM;
    if (byp && m_armed && wb_en && dstE == s) return valE;
    return m_regs[s];
  endfunction

  // Model state: an edge counts only once the file has seen one edge since reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) m_regs[i] <= 64'(i);
      m_count <= 32'd0;
      m_armed <= 1'b0;
    end else begin
      m_armed <= 1'b1;
      if (m_armed && wb_en) begin
        if (m_valid(dstE)) m_regs[dstE] <= valE;
        if (m_valid(dstM)) m_regs[dstM] <= valM;
        if (m_valid(dstE) || m_valid(dstM)) m_count <= m_count + 32'd1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 15; i++) begin
      chk("dump_byp", slot(dump_b, i), m_regs[i]);
      chk("dump_nobyp", slot(dump_n, i), m_regs[i]);
    end
    chk("count_byp", 64'(cnt_b), 64'(m_count));
    chk("count_nobyp", 64'(cnt_n), 64'(m_count));
    chk("rvalA_byp", rvalA_b, m_read(srcA, 1'b1));
    chk("rvalB_byp", rvalB_b, m_read(srcB, 1'b1));
    chk("rvalA_nobyp", rvalA_n, m_read(srcA, 1'b0));
    chk("rvalB_nobyp", rvalB_n, m_read(srcB, 1'b0));
  end

  task automatic set_in(input logic en, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] sa, input logic [3:0] sb);
    wb_en = en; dstE = de; valE = ve; dstM = dm; valM = vm; srcA = sa; srcB = sb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    set_in(1'b1, 4'd6, 64'hEE, 4'd8, 64'hFF, 4'd3, 4'hF);
    #1 reset_n = 1'b0;
    #11 reset_n = 1'b1;
    set_in(1'b0, 4'd6, 64'hEE, 4'd8, 64'hFF, 4'd3, 4'hF);
    tick();
    tick();

    for (int i = 0; i < 15; i++) chk("reset_dump", slot(dump_b, i), 64'(i));
    chk("reset_count", 64'(cnt_b), 64'd0);
    chk("reset_rvalA_r3", rvalA_b, 64'd3);
    chk("reset_rvalB_rnone", rvalB_b, 64'd0);
    srcA = 4'hF; srcB = 4'd3;
    #1;
    chk("reset_rvalA_rnone", rvalA_b, 64'd0);
    chk("reset_rvalB_r3", rvalB_b, 64'd3);

    set_in(1'b1, 4'd2, 64'h55, 4'hF, 64'h0, 4'd2, 4'd3);
    mid();
    chk("bypassE_rvalA", rvalA_b, 64'h55);
    chk("nobypass_rvalA", rvalA_n, 64'd2);
    tick();
    chk("writeE_r2", slot(dump_b, 2), 64'h55);
    chk("writeE_r3_hold", slot(dump_b, 3), 64'd3);
    chk("writeE_count", 64'(cnt_b), 64'd1);

    set_in(1'b1, 4'd4, 64'h100, 4'd4, 64'hABC, 4'd2, 4'd4);
    mid();
    chk("collide_bypass_rvalB", rvalB_b, 64'hABC);
    chk("collide_nobypass_rvalB", rvalB_n, 64'd4);
    tick();
    chk("collide_r4", slot(dump_b, 4), 64'hABC);
    chk("collide_count", 64'(cnt_b), 64'd2);

    set_in(1'b1, 4'd4, 64'h108, 4'd7, 64'hDEAD, 4'd7, 4'd4);
    mid();
    chk("popq_bypass_rvalA", rvalA_b, 64'hDEAD);
    chk("popq_bypass_rvalB", rvalB_b, 64'h108);
    tick();
    chk("popq_r4", slot(dump_b, 4), 64'h108);
    chk("popq_r7", slot(dump_b, 7), 64'hDEAD);
    chk("popq_count", 64'(cnt_b), 64'd3);

    set_in(1'b1, 4'hF, 64'h1234, 4'hF, 64'h5678, 4'd1, 4'hF);
    tick();
    chk("rnone_count", 64'(cnt_b), 64'd3);

    set_in(1'b0, 4'd1, 64'h99, 4'hF, 64'h0, 4'd1, 4'd4);
    mid();
    chk("stall_rvalA", rvalA_b, 64'd1);
    tick();
    chk("stall_r1", slot(dump_b, 1), 64'd1);
    chk("stall_count", 64'(cnt_b), 64'd3);

    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 4'(i), 64'h1000 + 64'(i), 4'(14 - i), 64'h2000 + 64'(i), 4'(i), 4'(14 - i));
      tick();
    end
    chk("sweep_r0", slot(dump_b, 0), 64'h1000);
    chk("sweep_r14", slot(dump_b, 14), 64'h2000);
    chk("sweep_r7_m_wins", slot(dump_b, 7), 64'h2007);
    chk("sweep_count", 64'(cnt_b), 64'd11);

    set_in(1'b1, 4'd5, 64'h77, 4'hF, 64'h0, 4'd5, 4'd6);
    tick();
    chk("pre_reset_r5", slot(dump_b, 5), 64'h77);
    chk("pre_reset_count", 64'(cnt_b), 64'd12);
    set_in(1'b1, 4'd6, 64'h66, 4'hF, 64'h0, 4'd5, 4'd6);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_r5", slot(dump_b, 5), 64'd5);
    chk("async_reset_count", 64'(cnt_b), 64'd0);
    chk("async_reset_nobyp_r5", slot(dump_n, 5), 64'd5);
    @(negedge clk);
    #4 reset_n = 1'b1;
    tick();
    chk("release_drop_r6", slot(dump_b, 6), 64'd6);
    chk("release_drop_count", 64'(cnt_b), 64'd0);
    tick();
    chk("post_release_r6", slot(dump_b, 6), 64'h66);
    chk("post_release_count", 64'(cnt_b), 64'd1);

    set_in(1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 4'd6, 4'd5);
    tick();
    mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
